// File: rtl/regfile_wb_if.sv
// Bundle of decode, ALU writeback, LSU load-return and register-file write
// signals shared by the writeback controller and its surrounding pipeline.
interface regfile_wb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int IW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic          dec_valid;
  logic [IW-1:0] dec_rs1;
  logic [IW-1:0] dec_rs2;
  logic [IW-1:0] dec_rd;
  logic          dec_is_load;
  logic          dec_stall;

  logic            alu_wr_en;
  logic [IW-1:0]   alu_wr_index;
  logic [XLEN-1:0] alu_wr_data;
  logic            alu_wb_stall;

  logic            lsu_valid;
  logic [IW-1:0]   lsu_index;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;

  logic            rf_wr_en;
  logic [IW-1:0]   rf_wr_index;
  logic [XLEN-1:0] rf_wr_data;

  logic [CW-1:0]   pending_cnt;
  logic            sb_err;

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_is_load,
    input  alu_wr_en, alu_wr_index, alu_wr_data,
    input  lsu_valid, lsu_index, lsu_data,
    output dec_stall, alu_wb_stall, lsu_ready,
    output rf_wr_en, rf_wr_index, rf_wr_data,
    output pending_cnt, sb_err
  );

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_is_load,
    output alu_wr_en, alu_wr_index, alu_wr_data,
    output lsu_valid, lsu_index, lsu_data,
    input  dec_stall, alu_wb_stall, lsu_ready,
    input  rf_wr_en, rf_wr_index, rf_wr_data,
    input  pending_cnt, sb_err
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port arbiter between ALU writeback and a one-entry load
// hold buffer, plus an outstanding-load scoreboard driving the decode stall.
module regfile_wb_ctrl #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_wb_if.slave  bus
);
  localparam int IW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);
  localparam int AW = $clog2(STARVE_MAX + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_MAX);

  logic            hold_valid_q, hold_valid_d;
  logic [IW-1:0]   hold_index_q, hold_index_d;
  logic [XLEN-1:0] hold_data_q,  hold_data_d;
  logic [AW-1:0]   hold_age_q,   hold_age_d;
  logic [NREG-1:0] pending_q,    pending_d;
  logic [CW-1:0]   pending_cnt_q, pending_cnt_d;
  logic            sb_err_q,     sb_err_d;

  logic forced, alu_ok, alu_win, hold_win, capture, issue_fire, alu_wb_stall, dec_stall;

  function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
    return (v == AGE_MAX) ? v : v + AW'(1);
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  function automatic logic hit(input logic [IW-1:0] x, input logic [NREG-1:0] p);
    return (x != '0) && p[x];
  endfunction

  always_comb begin
    // A starved hold entry takes the port unconditionally; ALU writes to x0 never compete.
    forced       = hold_valid_q && (hold_age_q == AGE_MAX);
    alu_ok       = bus.alu_wr_en && (bus.alu_wr_index != '0);
    alu_win      = alu_ok && !forced;
    hold_win     = hold_valid_q && (forced || !alu_ok);
    alu_wb_stall = forced && bus.alu_wr_en;
    dec_stall    = bus.dec_valid && (alu_wb_stall ||
                   hit(bus.dec_rs1, pending_q) || hit(bus.dec_rs2, pending_q) ||
                   hit(bus.dec_rd, pending_q));
    capture      = bus.lsu_valid && !hold_valid_q;
    issue_fire   = bus.dec_valid && !dec_stall && bus.dec_is_load && (bus.dec_rd != '0);

    hold_valid_d = hold_valid_q;
    hold_index_d = hold_index_q;
    hold_data_d  = hold_data_q;
    hold_age_d   = hold_age_q;
    if (capture) begin
      hold_valid_d = 1'b1;
      hold_index_d = bus.lsu_index;
      hold_data_d  = bus.lsu_data;
      hold_age_d   = '0;
    end else if (hold_win) begin
      hold_valid_d = 1'b0;
      hold_age_d   = '0;
    end else if (hold_valid_q) begin
      hold_age_d   = sat_inc(hold_age_q);
    end

    // Clear before set so a same-cycle reissue of the retiring index stays pending.
    pending_d = pending_q;
    if (hold_win)   pending_d[hold_index_q] = 1'b0;
    if (issue_fire) pending_d[bus.dec_rd]   = 1'b1;
    pending_cnt_d = popcount(pending_d);

    sb_err_d = sb_err_q || (capture && !pending_q[bus.lsu_index]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid_q  <= 1'b0;
      hold_age_q    <= '0;
      pending_q     <= '0;
      pending_cnt_q <= '0;
      sb_err_q      <= 1'b0;
    end else begin
      hold_valid_q  <= hold_valid_d;
      hold_age_q    <= hold_age_d;
      pending_q     <= pending_d;
      pending_cnt_q <= pending_cnt_d;
      sb_err_q      <= sb_err_d;
    end
  end

  // Hold payload is qualified by hold_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_index_q <= hold_index_d;
    hold_data_q  <= hold_data_d;
  end

  always_comb begin
    bus.rf_wr_en    = 1'b0;
    bus.rf_wr_index = '0;
    bus.rf_wr_data  = '0;
    if (alu_win) begin
      bus.rf_wr_en    = 1'b1;
      bus.rf_wr_index = bus.alu_wr_index;
      bus.rf_wr_data  = bus.alu_wr_data;
    end else if (hold_win && (hold_index_q != '0)) begin
      bus.rf_wr_en    = 1'b1;
      bus.rf_wr_index = hold_index_q;
      bus.rf_wr_data  = hold_data_q;
    end
  end

  assign bus.dec_stall    = dec_stall;
  assign bus.alu_wb_stall = alu_wb_stall;
  assign bus.lsu_ready    = !hold_valid_q;
  assign bus.pending_cnt  = pending_cnt_q;
  assign bus.sb_err       = sb_err_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scenario bench for regfile_wb_ctrl: every register-file write is checked
// against a queue of expected (index, data) pairs in issue order.
module tb_regfile_wb_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  regfile_wb_if #(.XLEN(32), .NREG(32)) bus ();

  regfile_wb_ctrl #(.XLEN(32), .NREG(32), .STARVE_MAX(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rf_wr_en === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got idx=%0d data=%08h required none", bus.rf_wr_index, bus.rf_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.rf_wr_index !== e.idx || bus.rf_wr_data !== e.data) begin
          bad++;
          $display("FAIL write_order got idx=%0d data=%08h required idx=%0d data=%08h",
                   bus.rf_wr_index, bus.rf_wr_data, e.idx, e.data);
        end
      end
    end
  end

  task automatic step; @(posedge clk); #1; endtask
  task automatic smp;  @(negedge clk);     endtask

  task automatic push(input int idx, input logic [31:0] d);
    wr_t e;
    e.idx  = 5'(idx);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic idle;
    bus.dec_valid = 0; bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_rd = 0; bus.dec_is_load = 0;
    bus.alu_wr_en = 0; bus.alu_wr_index = 0; bus.alu_wr_data = 0;
    bus.lsu_valid = 0; bus.lsu_index = 0; bus.lsu_data = 0;
  endtask

  task automatic issue(input int rs1, input int rs2, input int rd, input logic ld);
    bus.dec_valid = 1; bus.dec_rs1 = 5'(rs1); bus.dec_rs2 = 5'(rs2);
    bus.dec_rd = 5'(rd); bus.dec_is_load = ld;
  endtask

  task automatic test_reset;
    idle();
    reset_n = 0;
    smp();
    total++; if (bus.lsu_ready !== 1'b1) begin bad++; $display("FAIL rst_lsu_ready got=%0b req=1", bus.lsu_ready); end
    total++; if (bus.rf_wr_en !== 1'b0) begin bad++; $display("FAIL rst_rf_wr_en got=%0b req=0", bus.rf_wr_en); end
    total++; if (bus.pending_cnt !== 6'd0) begin bad++; $display("FAIL rst_pending_cnt got=%0d req=0", bus.pending_cnt); end
    total++; if (bus.sb_err !== 1'b0) begin bad++; $display("FAIL rst_sb_err got=%0b req=0", bus.sb_err); end
    total++; if (bus.dec_stall !== 1'b0 || bus.alu_wb_stall !== 1'b0) begin
      bad++; $display("FAIL rst_stalls got=%0b%0b req=00", bus.dec_stall, bus.alu_wb_stall); end
    step();
    reset_n = 1;
  endtask

  task automatic test_load_basic;
    step(); issue(0, 0, 5, 1); smp();
    total++; if (bus.dec_stall !== 1'b0) begin bad++; $display("FAIL basic_issue_stall got=%0b req=0", bus.dec_stall); end
    step(); idle(); smp();
    total++; if (bus.pending_cnt !== 6'd1) begin bad++; $display("FAIL basic_cnt_up got=%0d req=1", bus.pending_cnt); end
    step(); smp();
    step(); bus.lsu_valid = 1; bus.lsu_index = 5; bus.lsu_data = 32'hDEADBEEF; push(5, 32'hDEADBEEF); smp();
    total++; if (bus.rf_wr_en !== 1'b0) begin bad++; $display("FAIL basic_arrival_write got=%0b req=0", bus.rf_wr_en); end
    step(); idle(); issue(5, 0, 0, 0); smp();
    total++; if (bus.rf_wr_en !== 1'b1) begin bad++; $display("FAIL basic_hold_write got=%0b req=1", bus.rf_wr_en); end
    total++; if (bus.dec_stall !== 1'b1) begin bad++; $display("FAIL basic_write_cycle_stall got=%0b req=1", bus.dec_stall); end
    step(); smp();
    total++; if (bus.dec_stall !== 1'b0) begin bad++; $display("FAIL basic_stall_release got=%0b req=0", bus.dec_stall); end
    total++; if (bus.pending_cnt !== 6'd0) begin bad++; $display("FAIL basic_cnt_down got=%0d req=0", bus.pending_cnt); end
    step(); idle();
  endtask

  task automatic test_raw;
    issue(0, 0, 5, 1); smp();
    total++; if (bus.dec_stall !== 1'b0) begin bad++; $display("FAIL raw_issue got=%0b req=0", bus.dec_stall); end
    step(); issue(0, 5, 10, 0);
    bus.lsu_valid = 1; bus.lsu_index = 5; bus.lsu_data = 32'h12345678; push(5, 32'h12345678); smp();
    total++; if (bus.dec_stall !== 1'b1) begin bad++; $display("FAIL raw_stall_pending got=%0b req=1", bus.dec_stall); end
    step(); bus.lsu_valid = 0; smp();
    total++; if (bus.dec_stall !== 1'b1) begin bad++; $display("FAIL raw_stall_write_cycle got=%0b req=1", bus.dec_stall); end
    step(); smp();
    total++; if (bus.dec_stall !== 1'b0) begin bad++; $display("FAIL raw_stall_after got=%0b req=0", bus.dec_stall); end
    step(); issue(0, 0, 0, 1); smp();
    total++; if (bus.dec_stall !== 1'b0) begin bad++; $display("FAIL raw_x0_stall got=%0b req=0", bus.dec_stall); end
    step(); idle(); smp();
    total++; if (bus.pending_cnt !== 6'd0) begin bad++; $display("FAIL raw_x0_pending got=%0d req=0", bus.pending_cnt); end
    step();
  endtask

  task automatic test_starve;
    int idxs[4] = '{3, 4, 6, 8};
    issue(0, 0, 7, 1);
    step(); idle(); bus.lsu_valid = 1; bus.lsu_index = 7; bus.lsu_data = 32'hA7A7A7A7;
    for (int i = 0; i < 4; i++) begin
      step(); bus.lsu_valid = 0;
      bus.alu_wr_en = 1; bus.alu_wr_index = 5'(idxs[i]); bus.alu_wr_data = 32'h100 + 32'(idxs[i]);
      push(idxs[i], 32'h100 + 32'(idxs[i])); smp();
      total++; if (bus.alu_wb_stall !== 1'b0) begin bad++; $display("FAIL starve_alu_win%0d got=%0b req=0", i, bus.alu_wb_stall); end
    end
    step(); bus.alu_wr_index = 9; bus.alu_wr_data = 32'h109; push(7, 32'hA7A7A7A7); smp();
    total++; if (bus.alu_wb_stall !== 1'b1) begin bad++; $display("FAIL starve_forced got=%0b req=1", bus.alu_wb_stall); end
    total++; if (bus.rf_wr_index !== 5'd7) begin bad++; $display("FAIL starve_forced_idx got=%0d req=7", bus.rf_wr_index); end
    step(); push(9, 32'h109); smp();
    total++; if (bus.alu_wb_stall !== 1'b0) begin bad++; $display("FAIL starve_alu_retry got=%0b req=0", bus.alu_wb_stall); end
    step(); idle();
  endtask

  task automatic test_back_to_back;
    issue(0, 0, 20, 1);
    step(); issue(0, 0, 21, 1);
    step(); idle(); bus.lsu_valid = 1; bus.lsu_index = 20; bus.lsu_data = 32'h20202020; push(20, 32'h20202020); smp();
    total++; if (bus.lsu_ready !== 1'b1) begin bad++; $display("FAIL b2b_first_ready got=%0b req=1", bus.lsu_ready); end
    step(); bus.lsu_index = 21; bus.lsu_data = 32'h21212121; smp();
    total++; if (bus.lsu_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_blocked got=%0b req=0", bus.lsu_ready); end
    step(); push(21, 32'h21212121); smp();
    total++; if (bus.lsu_ready !== 1'b1) begin bad++; $display("FAIL b2b_second_ready got=%0b req=1", bus.lsu_ready); end
    step(); bus.lsu_valid = 0; smp();
    step(); smp();
    total++; if (bus.pending_cnt !== 6'd0) begin bad++; $display("FAIL b2b_pending got=%0d req=0", bus.pending_cnt); end
    total++; if (bus.sb_err !== 1'b0) begin bad++; $display("FAIL b2b_sb_err got=%0b req=0", bus.sb_err); end
  endtask

  task automatic test_sb_err;
    step(); bus.lsu_valid = 1; bus.lsu_index = 12; bus.lsu_data = 32'h0C0C0C0C; push(12, 32'h0C0C0C0C); smp();
    total++; if (bus.sb_err !== 1'b0) begin bad++; $display("FAIL sberr_before got=%0b req=0", bus.sb_err); end
    step(); bus.lsu_valid = 0; smp();
    total++; if (bus.sb_err !== 1'b1) begin bad++; $display("FAIL sberr_set got=%0b req=1", bus.sb_err); end
    step(); smp(); step(); smp();
    total++; if (bus.sb_err !== 1'b1) begin bad++; $display("FAIL sberr_sticky got=%0b req=1", bus.sb_err); end
  endtask

  task automatic test_reset_mid;
    step(); issue(0, 0, 1, 1);
    step(); issue(0, 0, 2, 1);
    step(); issue(0, 0, 3, 1);
    step(); idle(); bus.lsu_valid = 1; bus.lsu_index = 1; bus.lsu_data = 32'h11111111;
    step(); bus.lsu_valid = 0; bus.alu_wr_en = 1; bus.alu_wr_index = 15; bus.alu_wr_data = 32'hF0F0F0F0;
    push(15, 32'hF0F0F0F0); smp();
    total++; if (bus.pending_cnt !== 6'd3) begin bad++; $display("FAIL rmid_pending_pre got=%0d req=3", bus.pending_cnt); end
    total++; if (bus.lsu_ready !== 1'b0) begin bad++; $display("FAIL rmid_hold_pre got=%0b req=0", bus.lsu_ready); end
    step(); idle(); reset_n = 0; #1;
    total++; if (bus.pending_cnt !== 6'd0) begin bad++; $display("FAIL rmid_pending got=%0d req=0", bus.pending_cnt); end
    total++; if (bus.lsu_ready !== 1'b1) begin bad++; $display("FAIL rmid_lsu_ready got=%0b req=1", bus.lsu_ready); end
    total++; if (bus.rf_wr_en !== 1'b0) begin bad++; $display("FAIL rmid_rf_wr_en got=%0b req=0", bus.rf_wr_en); end
    step(); step(); reset_n = 1;
    for (int i = 0; i < 4; i++) begin step(); smp(); end
    total++; if (bus.sb_err !== 1'b0) begin bad++; $display("FAIL rmid_sb_err got=%0b req=0", bus.sb_err); end
    total++; if (bus.pending_cnt !== 6'd0) begin bad++; $display("FAIL rmid_pending_post got=%0d req=0", bus.pending_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_raw();
    test_starve();
    test_back_to_back();
    test_sb_err();
    test_reset_mid();
    step(); smp();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL missing_writes got=%0d outstanding req=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Writeback controller and scoreboard for the 2-read/1-write register file. It arbitrates the single write port between the ALU writeback path (single cycle, fixed timing) and the load/store unit (LSU) load-return path (variable latency). It tracks registers with outstanding loads and raises a decode stall on RAW/WAW hazards. It sits between the decode/execute pipeline, the LSU and the register file write port.

Parameters:
XLEN, 32, data width of the register file write port
NREG, 32, number of architectural registers (index width is clog2(NREG) = 5)
STARVE_MAX, 4, consecutive cycles a held load result may lose arbitration before it forces the port

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
dec_valid  input  1  decode slot holds a valid instruction
dec_rs1  input  5  source index 1
dec_rs2  input  5  source index 2
dec_rd  input  5  destination index
dec_is_load  input  1  instruction is a load
dec_stall  output  1  hazard stall to decode; combinational
alu_wr_en  input  1  ALU writeback request
alu_wr_index  input  5  ALU destination
alu_wr_data  input  XLEN  ALU result
alu_wb_stall  output  1  ALU writeback refused this cycle; pipeline must hold; combinational
lsu_valid  input  1  load data valid
lsu_index  input  5  load destination
lsu_data  input  XLEN  load data
lsu_ready  output  1  hold buffer empty; equals !hold_valid
rf_wr_en  output  1  to register file wr_en
rf_wr_index  output  5  to register file wr_index
rf_wr_data  output  XLEN  to register file wr_data
pending_cnt  output  6  number of registers with an outstanding load
sb_err  output  1  sticky: load returned to a non-pending index

Behaviour:
- Reset (async, reset_n low): pending[] = 0, hold_valid = 0, hold_age = 0, pending_cnt = 0, sb_err = 0.
  - Outputs then read: lsu_ready = 1, rf_wr_en = 0, dec_stall = 0, alu_wb_stall = 0.
  - Reset mid-operation discards all outstanding loads and any held data.
- Hold buffer (1 entry: hold_index, hold_data):
  - Captures on lsu_valid && lsu_ready, at the next clock edge.
  - Load data never writes the port in its arrival cycle; minimum load-to-port latency is 1 cycle.
- hold_age:
  - Cleared on capture.
  - Increments (saturating at STARVE_MAX) on each cycle hold_valid = 1 and the hold entry does not win the port.
- Port arbitration (combinational, each cycle):
  - Forced: hold_valid && hold_age == STARVE_MAX. Hold writes; alu_wb_stall = alu_wr_en.
  - Else if alu_wr_en && alu_wr_index != 0: ALU writes; hold, if valid, waits.
  - Else if hold_valid: hold writes.
  - Else: rf_wr_en = 0.
- Writes to index 0:
  - rf_wr_en is never asserted for index 0.
  - ALU write to x0 is dropped and does not block hold.
  - A held entry with index 0 is consumed without a write.
- Hold win: hold_valid clears at the edge; lsu_ready returns to 1 the following cycle.
- rf_wr_data/rf_wr_index follow the selected source. They are 0 when idle.
- Scoreboard:
  - issue_fire = dec_valid && !dec_stall && dec_is_load && dec_rd != 0. Sets pending[dec_rd].
  - A hold write clears pending[hold_index].
  - Same-index set and clear in one cycle: set wins.
  - pending_cnt tracks the set bits: +1, -1, or unchanged when set and clear occur together.
- Scoreboard error: a captured lsu_index whose pending bit is 0 sets sb_err. sb_err is cleared only by reset.
- dec_stall = dec_valid && (alu_wb_stall || hit(rs1) || hit(rs2) || hit(rd)).
  - hit(x) = x != 0 && pending[x], using registered pending.
  - The clearing write cycle still stalls, so a consumer proceeds the cycle after the load writes.
- No-loss rule: a load result is written exactly once.

Test Plan:
- Load issue rd=5, LSU returns index 5 data 0xDEADBEEF 3 cycles later, no ALU traffic -> rf_wr_en/index 5/data 0xDEADBEEF one cycle after capture; pending_cnt 1->0; dec_stall low one cycle later.
- Pending x5, decode rs2=5 -> dec_stall=1 until the cycle after the hold write. rs1=0 with a pending x0 attempt -> no pending set, no stall.
- Hold valid (x7) with ALU writing x3,x4,x6,x8,x9 in consecutive cycles, STARVE_MAX=4 -> ALU wins 4 cycles; 5th cycle hold writes x7 and alu_wb_stall=1; the ALU x9 write is taken the next cycle.
- Two LSU returns back-to-back -> second beat sees lsu_ready=0. It is accepted only after the first hold write; both written, in order.
- LSU returns index 12 with pending[12]=0 -> sb_err=1 and stays 1; data still written to x12.
- Assert reset_n=0 with 3 pending loads and hold_valid=1 -> pending_cnt=0, lsu_ready=1, rf_wr_en=0 immediately; no write of held data after release.
